// File: rtl/body_scanner_if.sv
// Request/result bundle between the game FSM (master) and the body scanner (slave).
// The body array is packed so entry 0 (the head) sits in the low byte.
interface body_scanner_if #(
  parameter int MAX_LENGTH = 50
);
  logic                       start;
  logic [MAX_LENGTH-1:0][7:0] body;
  logic [7:0]                 head;
  logic [7:0]                 curr_length;
  logic [7:0]                 apple;
  logic                       busy;
  logic                       done;
  logic                       self_hit;
  logic                       apple_hit;

  modport master (
    output start, body, head, curr_length, apple,
    input  busy, done, self_hit, apple_hit
  );

  modport slave (
    input  start, body, head, curr_length, apple,
    output busy, done, self_hit, apple_hit
  );
endinterface

// File: rtl/body_scanner.sv
// Walks a snapshot of the snake body one segment per clock and reports
// self-collision of the new head and apple-on-snake for the last scan.
module body_scanner #(
  parameter int MAX_LENGTH = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  body_scanner_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_LENGTH);
  localparam logic [7:0]       LEN_MAX8 = 8'(MAX_LENGTH - 1);
  localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(MAX_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state, state_d;
  logic [IDX_W-1:0]           idx, idx_d;
  logic [IDX_W-1:0]           len_q;
  logic [MAX_LENGTH-1:0][7:0] seg;
  logic [7:0]                 head_q;
  logic [7:0]                 apple_q;
  logic                       self_q, self_d;
  logic                       apple_hit_q, apple_hit_d;
  logic                       load;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    self_d      = self_q;
    apple_hit_d = apple_hit_q;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load        = 1'b1;
          idx_d       = '0;
          self_d      = 1'b0;
          apple_hit_d = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        apple_hit_d = apple_hit_q | (seg[idx] == apple_q);
        // Entry 0 is the old head; the new head landing there is not a collision.
        if (idx != '0) self_d = self_q | (seg[idx] == head_q);
        if (idx == len_q) state_d = DONE;
        else              idx_d   = idx + IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the snapshot array is reset too, so a restart never exposes stale segments.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      state       <= IDLE;
      idx         <= '0;
      self_q      <= 1'b0;
      apple_hit_q <= 1'b0;
      len_q       <= '0;
      seg         <= '0;
      head_q      <= '0;
      apple_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      state       <= state_d;
      idx         <= idx_d;
      self_q      <= self_d;
      apple_hit_q <= apple_hit_d;
      if (load) begin
        seg     <= bus.body;
        head_q  <= bus.head;
        apple_q <= bus.apple;
        len_q   <= (bus.curr_length > LEN_MAX8) ? LEN_MAX : bus.curr_length[IDX_W-1:0];
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.self_hit  = self_q;
  assign bus.apple_hit = apple_hit_q;

endmodule

// File: tb/tb_body_scanner.sv
// Directed bench for body_scanner: a per-scan reference model checked every cycle,
// plus literal expectations for latency and hit flags on each directed scan.
module tb_body_scanner;

  localparam int ML = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync = 1'b0;

  body_scanner_if #(.MAX_LENGTH(ML)) bus ();

  body_scanner #(.MAX_LENGTH(ML)) dut (
    .clk  (clk),
    .rst  (rst),
    .sync (sync),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the outcome of a scan is a pure function of what was presented at start.
  function automatic logic [1:0] ref_scan(input logic [ML-1:0][7:0] b, input logic [7:0] h,
                                          input logic [7:0] a, input logic [7:0] len);
    int  l;
    logic s, ap;
    l  = (len > 8'(ML - 1)) ? ML - 1 : int'(len);
    s  = 1'b0;
    ap = 1'b0;
    for (int i = 0; i <= l; i++) begin
      if (b[i] == a) ap = 1'b1;
      if (i > 0 && b[i] == h) s = 1'b1;
    end
    return {s, ap};
  endfunction

  // Model state: cycles elapsed since the accepted start edge.
  bit m_active = 1'b0;
  int m_cnt    = 0;
  int m_len    = 0;
  bit m_self   = 1'b0;
  bit m_apple  = 1'b0;

  always @(posedge clk) begin
    if (rst || sync) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_self   <= 1'b0;
      m_apple  <= 1'b0;
    end else if (m_active) begin
      if (m_cnt == m_len + 2) m_active <= 1'b0;
      else                    m_cnt    <= m_cnt + 1;
    end else if (bus.start) begin
      {m_self, m_apple} <= ref_scan(bus.body, bus.head, bus.apple, bus.curr_length);
      m_len    <= (bus.curr_length > 8'(ML - 1)) ? ML - 1 : int'(bus.curr_length);
      m_cnt    <= 1;
      m_active <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(m_active && m_cnt == m_len + 2));
      if (!m_active || m_cnt == m_len + 2) begin
        check("self_hit", 32'(bus.self_hit), 32'(m_self));
        check("apple_hit", 32'(bus.apple_hit), 32'(m_apple));
      end
    end
  end

  // One scan; mid_start pulses start again at that cycle, mutate alters body after start.
  task automatic do_scan(input string name, input logic [7:0] h, input logic [7:0] a,
                         input logic [7:0] len, input int exp_lat, input bit exp_self,
                         input bit exp_apple, input int mid_start, input bit mutate);
    int n;
    @(posedge clk); #1;
    bus.head = h; bus.apple = a; bus.curr_length = len; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 300) begin
      if (mutate && n == 1) bus.body[1] = h;
      @(posedge clk); #1;
      n++;
      if (n == mid_start) begin bus.start = 1'b1; bus.head = 8'h43; end
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (mutate) bus.body[1] = 8'h44;
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_self"}, 32'(bus.self_hit), 32'(exp_self));
    check({name, "_apple"}, 32'(bus.apple_hit), 32'(exp_apple));
  endtask

  task automatic abort_scan(input string name, input bit use_sync);
    int dones;
    @(posedge clk); #1;
    bus.head = 8'h45; bus.apple = 8'h44; bus.curr_length = 8'd40; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    if (use_sync) sync = 1'b1; else rst = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0; rst = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_apple"}, 32'(bus.apple_hit), 32'd0);
    check({name, "_self"}, 32'(bus.self_hit), 32'd0);
    dones = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check({name, "_no_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.body = '0; bus.head = '0; bus.curr_length = '0; bus.apple = '0;
    bus.body[0] = 8'h45; bus.body[1] = 8'h44; bus.body[2] = 8'h43; bus.body[3] = 8'h42;
    bus.body[ML-1] = 8'hA7;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_self", 32'(bus.self_hit), 32'd0);
    check("reset_apple", 32'(bus.apple_hit), 32'd0);
    cmp_en = 1'b1;

    //       name              head   apple  len     lat self apple mid mut
    do_scan("no_hit",          8'h46, 8'h99, 8'd3,   5,  0,   0,    0,  0);
    do_scan("self_hit",        8'h43, 8'h99, 8'd3,   5,  1,   0,    0,  0);
    do_scan("head_idx0",       8'h45, 8'h99, 8'd3,   5,  0,   0,    0,  0);
    do_scan("apple_hit",       8'h46, 8'h42, 8'd3,   5,  0,   1,    0,  0);
    do_scan("apple_beyond_L",  8'h46, 8'h42, 8'd2,   4,  0,   0,    0,  0);
    do_scan("zero_fill",       8'h46, 8'h00, 8'd3,   5,  0,   0,    0,  0);
    do_scan("clamp200",        8'hA7, 8'h99, 8'd200, 51, 1,   0,    0,  0);
    do_scan("len49",           8'hA7, 8'h45, 8'd49,  51, 1,   1,    0,  0);
    do_scan("len50",           8'h42, 8'hA7, 8'd50,  51, 1,   1,    0,  0);
    do_scan("len0",            8'h45, 8'h45, 8'd0,   2,  0,   1,    0,  0);
    do_scan("start_ignored",   8'h46, 8'h99, 8'd3,   5,  0,   0,    2,  0);
    do_scan("snapshot",        8'h46, 8'h99, 8'd3,   5,  0,   0,    0,  1);

    abort_scan("sync_abort", 1'b1);
    do_scan("after_sync",      8'h44, 8'h43, 8'd3,   5,  1,   1,    0,  0);
    abort_scan("rst_abort", 1'b0);

    // Reset has priority over a coincident start.
    @(posedge clk); #1;
    bus.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b0;
    check("rst_vs_start_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
